// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port with programmable wait states.
// Optional macro DMEM_ALIGN_CHECK_EN enables misaligned-access errors.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          we_q;
  logic          sgn_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          err;
  logic          commit;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   word;
  logic [31:0]   sh;
  logic [31:0]   ext;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign commit    = (state == WAIT) && (cnt == 4'd0);
  assign idx       = addr_q[AW+1:2];
  assign word      = mem[idx];
  assign sh        = word >> {lane, 3'b000};

  always_comb begin
    err  = 1'b0;
    lane = addr_q[1:0];
    be   = 4'b0000;
    wd   = wdata_q;
    ext  = 32'h0;
`ifdef DMEM_ALIGN_CHECK_EN
    err = (size_q == 2'b11)
        | ((size_q == 2'b01) & addr_q[0])
        | ((size_q == 2'b10) & (|addr_q[1:0]));
`else
    err = (size_q == 2'b11);
`endif
    unique case (1'b1)
      size_q == 2'b00: begin
        lane = addr_q[1:0];
        be   = 4'b0001 << lane;
        wd   = {4{wdata_q[7:0]}};
        ext  = {{24{sgn_q & sh[7]}}, sh[7:0]};
      end
      size_q == 2'b01: begin
        lane = {addr_q[1], 1'b0};
        be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wd   = {2{wdata_q[15:0]}};
        ext  = {{16{sgn_q & sh[15]}}, sh[15:0]};
      end
      size_q == 2'b10: begin
        lane = 2'b00;
        be   = 4'b1111;
        wd   = wdata_q;
        ext  = sh;
      end
      default: begin
        lane = 2'b00;
        be   = 4'b0000;
        ext  = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      sgn_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      size_q    <= 2'b00;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            sgn_q   <= req_signed;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
            size_q  <= req_size;
            cnt     <= 4'(WAIT_STATES);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_err   <= err;
            rsp_rdata <= (we_q | err) ? 32'h0 : ext;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit && we_q && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

  localparam int D = 16;
  localparam int W = 2;
  localparam int NB = 4 * D;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [NB];

  dmem_responder #(.DEPTH_WORDS(D), .WAIT_STATES(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_size(req_size),
    .req_signed(req_signed),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array, access by byte count.
  function automatic logic [32:0] model(input logic we, input logic [31:0] a,
                                        input logic [31:0] wd,
                                        input logic [1:0] sz, input logic sg);
    int n;
    int b;
    logic [31:0] v;
    logic [63:0] msk;
    logic e;
    e = (sz == 2'b11);
`ifdef DMEM_ALIGN_CHECK_EN
    if (sz == 2'b01 && (a % 2) != 0) e = 1'b1;
    if (sz == 2'b10 && (a % 4) != 0) e = 1'b1;
`endif
    if (e) return {1'b1, 32'h0};
    n = 1 << sz;
    b = int'(a % NB);
    b = b - (b % n);
    if (we) begin
      for (int i = 0; i < n; i++) mm[b+i] = wd[8*i +: 8];
      return {1'b0, 32'h0};
    end
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mm[b+i]) << (8*i));
    msk = (64'h1 << (8*n)) - 64'h1;
    if (sg && v[8*n-1]) v = v | ~msk[31:0];
    return {1'b0, v};
  endfunction

  task automatic xfer(input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] sz,
                      input logic sg, input int hold,
                      output logic [31:0] rd, output logic er);
    int lat;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_wdata  = wd;
    req_size   = sz;
    req_signed = sg;
    rsp_ready  = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_size  = 2'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, W + 1);
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err", rsp_err, er);
      chk("hold_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("done_valid", rsp_valid, 1'b0);
    chk("done_req_ready", req_ready, 1'b1);
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] sz,
                     input logic sg, input int hold,
                     output logic [31:0] rd, output logic er);
    logic [32:0] e;
    e = model(we, a, wd, sz, sg);
    xfer(we, a, wd, sz, sg, hold, rd, er);
    chk({tag, "_rdata"}, rd, e[31:0]);
    chk({tag, "_err"}, er, e[32]);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] p20;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", rsp_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < D; i++)
      txn("init", 1'b1, 32'(4*i), $urandom, 2'b10, 1'b0, 0, rd, er);

    txn("st_beef", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, rd, er);
    txn("ld_beef", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
    chk("ld_beef_c", rd, 32'hDEADBEEF);
    txn("lb13s", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, rd, er);
    chk("lb13s_c", rd, 32'hFFFFFFDE);
    txn("lb13u", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, rd, er);
    chk("lb13u_c", rd, 32'h000000DE);
    txn("lh10s", 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 0, rd, er);
    chk("lh10s_c", rd, 32'hFFFFBEEF);
    txn("sb11", 1'b1, 32'h11, 32'h5A, 2'b00, 1'b0, 0, rd, er);
    txn("lw10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
    chk("lw10_c", rd, 32'hDEAD5AEF);

    txn("sw12", 1'b1, 32'h12, 32'hCAFEF00D, 2'b10, 1'b0, 0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("sw12_err_c", er, 1'b1);
`else
    chk("sw12_err_c", er, 1'b0);
`endif
    txn("lw10b", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("lw10b_c", rd, 32'hDEAD5AEF);
`else
    chk("lw10b_c", rd, 32'hCAFEF00D);
`endif
    txn("sz11", 1'b1, 32'h10, 32'h11111111, 2'b11, 1'b0, 0, rd, er);
    chk("sz11_err_c", er, 1'b1);
    txn("ld11", 1'b0, 32'h10, 32'h0, 2'b11, 1'b1, 0, rd, er);
    chk("ld11_err_c", er, 1'b1);

    txn("hold5", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, rd, er);

    txn("ld20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, p20, er);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_size  = 2'b10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_err", rsp_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    txn("ld20_after", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, rd, er);
    chk("ld20_kept", rd, p20);
    txn("alias", 1'b0, 32'h20 + NB, 32'h0, 2'b10, 1'b0, 0, rd, er);
    chk("alias_c", rd, p20);

    for (int i = 0; i < 80; i++) begin
      txn("rnd", 1'($urandom), $urandom, $urandom, 2'($urandom),
          1'($urandom), int'($urandom_range(0, 2)), rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
